// File: rtl/cpu_test_sequencer.sv
// cpu_test_sequencer: walks a table of CPU self-tests. Each test resets the
// core, requests an image load, runs it for a programmed number of cycles,
// then compares a probed register against the expected value and reports.
//
// state  | meaning
// IDLE   | waiting for start, CPU held in reset
// RST    | CPU held in reset for RESET_CYCLES cycles
// LOAD   | image load requested, waiting for load_ack or timeout
// RUN    | CPU released, down-counting the programmed run length
// CHECK  | CPU still running, probe_data compared against expected value
// REPORT | one-cycle result strobe, CPU back in reset
// DONE   | all tests reported, tallies held until the next start
module cpu_test_sequencer #(
  parameter int NUM_TESTS    = 3,
  parameter int DATA_W       = 32,
  parameter int SEL_W        = 5,
  parameter int CYC_W        = 16,
  parameter int RESET_CYCLES = 2,
  parameter int LOAD_TIMEOUT = 1024,
  parameter int ID_W         = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  output logic                        cpu_reset_n,
  output logic                        load_req,
  output logic [ID_W-1:0]             load_id,
  input  logic                        load_ack,
  output logic [SEL_W-1:0]            probe_sel,
  input  logic [DATA_W-1:0]           probe_data,
  input  logic [NUM_TESTS*CYC_W-1:0]  test_cycles,
  input  logic [NUM_TESTS*DATA_W-1:0] test_expect,
  input  logic [NUM_TESTS*SEL_W-1:0]  test_sel,
  output logic                        busy,
  output logic                        done,
  output logic                        result_valid,
  output logic [ID_W-1:0]             result_id,
  output logic                        result_pass,
  output logic [ID_W:0]               pass_count,
  output logic [ID_W:0]               fail_count,
  output logic [NUM_TESTS-1:0]        fail_mask
);

  // One shared down-counter serves the reset, load-timeout and run phases,
  // so it must be wide enough for the largest of the three.
  localparam int TMR_A = (CYC_W > $clog2(LOAD_TIMEOUT + 1)) ? CYC_W : $clog2(LOAD_TIMEOUT + 1);
  localparam int TMR_W = (TMR_A > $clog2(RESET_CYCLES + 1)) ? TMR_A : $clog2(RESET_CYCLES + 1);

  localparam logic [TMR_W-1:0] RST_LOAD = TMR_W'(RESET_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LOAD  = TMR_W'(LOAD_TIMEOUT - 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_TESTS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RST    = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_REPORT = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]       state, state_nxt;
  logic [ID_W-1:0]  idx, idx_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic [TMR_W-1:0] run_load;
  logic             clear_run;
  logic             rpt_load;
  logic             rpt_pass;
  logic             busy_nxt;

  logic [CYC_W-1:0]  cyc_tab [NUM_TESTS];
  logic [DATA_W-1:0] exp_tab [NUM_TESTS];
  logic [SEL_W-1:0]  sel_tab [NUM_TESTS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TESTS; gi++) begin : g_tab
      assign cyc_tab[gi] = test_cycles[gi*CYC_W +: CYC_W];
      assign exp_tab[gi] = test_expect[gi*DATA_W +: DATA_W];
      assign sel_tab[gi] = test_sel[gi*SEL_W +: SEL_W];
    end
  endgenerate

  // Run length reload value; a programmed 0 behaves as a 1-cycle run.
  always_comb begin
    run_load = '0;
    if (cyc_tab[idx] != '0) run_load = TMR_W'(cyc_tab[idx]) - 1'b1;
  end

  // Next-state, index and timer logic.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    tmr_nxt   = tmr;
    clear_run = 1'b0;
    rpt_load  = 1'b0;
    rpt_pass  = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_RST;
          idx_nxt   = '0;
          tmr_nxt   = RST_LOAD;
          clear_run = 1'b1;
        end
      end
      S_RST: begin
        if (tmr == '0) begin
          state_nxt = S_LOAD;
          tmr_nxt   = TO_LOAD;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      S_LOAD: begin
        // An ack on the final timeout cycle still wins over the timeout.
        if (load_ack) begin
          state_nxt = S_RUN;
          tmr_nxt   = run_load;
        end else if (tmr == '0) begin
          state_nxt = S_REPORT;
          rpt_load  = 1'b1;
          rpt_pass  = 1'b0;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      S_RUN: begin
        if (tmr == '0) state_nxt = S_CHECK;
        else           tmr_nxt   = tmr - 1'b1;
      end
      S_CHECK: begin
        state_nxt = S_REPORT;
        rpt_load  = 1'b1;
        rpt_pass  = (probe_data == exp_tab[idx]);
      end
      S_REPORT: begin
        if (idx == LAST_ID) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_RST;
          idx_nxt   = idx + 1'b1;
          tmr_nxt   = RST_LOAD;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy_nxt = (state_nxt != S_IDLE) && (state_nxt != S_DONE);

  // State, control registers and registered outputs derived from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      idx          <= '0;
      tmr          <= '0;
      cpu_reset_n  <= 1'b0;
      load_req     <= 1'b0;
      load_id      <= '0;
      probe_sel    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
      result_id    <= '0;
      result_pass  <= 1'b0;
      pass_count   <= '0;
      fail_count   <= '0;
      fail_mask    <= '0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      tmr          <= tmr_nxt;
      cpu_reset_n  <= (state_nxt == S_RUN) || (state_nxt == S_CHECK);
      load_req     <= (state_nxt == S_LOAD);
      load_id      <= (state_nxt == S_LOAD) ? idx_nxt : '0;
      probe_sel    <= busy_nxt ? sel_tab[idx_nxt] : '0;
      busy         <= busy_nxt;
      done         <= (state_nxt == S_DONE);
      result_valid <= rpt_load;
      result_id    <= rpt_load ? idx : '0;
      result_pass  <= rpt_load & rpt_pass;
      if (clear_run) begin
        pass_count <= '0;
        fail_count <= '0;
        fail_mask  <= '0;
      end else if (rpt_load) begin
        if (rpt_pass) begin
          pass_count <= pass_count + 1'b1;
        end else begin
          fail_count <= fail_count + 1'b1;
          fail_mask  <= fail_mask | (NUM_TESTS'(1) << idx);
        end
      end
    end
  end

endmodule

// File: doc/cpu_test_sequencer.md
# cpu_test_sequencer

Synthesizable, parametrised successor of the MIPS bring-up bench: runs a table of NUM_TESTS self-checking tests against the CPU core. Each test resets the CPU, requests a memory image load, runs for a programmed cycle count, then compares a probed register against an expected value. Per-test results are reported, and pass/fail tallies are accumulated. Sits between the board-level harness (image loader, register probe mux) and the `Mips` core's reset input.

## Interface
Parameters:
- NUM_TESTS, 3, number of table entries (≥1)
- DATA_W, 32, probe/expected data width
- SEL_W, 5, probe select width (register index)
- CYC_W, 16, run-cycle count width
- RESET_CYCLES, 2, cycles cpu_reset_n is held low before load (≥1)
- LOAD_TIMEOUT, 1024, max cycles waiting for load_ack
- ID_W (derived), max(1, clog2(NUM_TESTS))

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a full run (pulse)
- cpu_reset_n  out  1  active-low reset to CPU
- load_req  out  1  image load request (level)
- load_id  out  ID_W  test index whose image is to be loaded
- load_ack  in  1  loader done
- probe_sel  out  SEL_W  register to observe
- probe_data  in  DATA_W  observed register value
- test_cycles  in  NUM_TESTS*CYC_W  run length per test, entry i at [i*CYC_W +: CYC_W]
- test_expect  in  NUM_TESTS*DATA_W  expected value per test
- test_sel  in  NUM_TESTS*SEL_W  probe select per test
- busy  out  1  run in progress
- done  out  1  run complete (level until next start/reset)
- result_valid  out  1  one-cycle per-test result strobe
- result_id  out  ID_W  index for result_valid
- result_pass  out  1  pass flag for result_valid
- pass_count, fail_count  out  ID_W+1  tallies
- fail_mask  out  NUM_TESTS  bit i set if test i failed

## Operation
- States: IDLE, RST, LOAD, RUN, CHECK, REPORT, DONE.
- IDLE/DONE: cpu_reset_n=0, load_req=0. `start` moves to RST with index=0 and clears pass_count, fail_count, fail_mask, and done. `start` is ignored in all other states.
- RST: cpu_reset_n=0 for exactly RESET_CYCLES cycles, then LOAD.
- LOAD: cpu_reset_n=0, load_req=1, load_id=index. When load_ack is sampled high, go to RUN. If no ack arrives within LOAD_TIMEOUT cycles, record a fail for this test and go to REPORT, skipping RUN. load_ack is ignored outside LOAD.
- RUN: cpu_reset_n=1. The counter loads test_cycles[index]; a value of 0 is treated as 1. RUN lasts exactly that many cycles, then CHECK.
- CHECK: cpu_reset_n=1. Sample probe_data. pass = (probe_data == test_expect[index]), full DATA_W compare.
- REPORT: result_valid=1 for one cycle with result_id and result_pass. Update the tally and fail_mask. cpu_reset_n=0. If index==NUM_TESTS-1, go to DONE; otherwise increment index and go to RST.
- probe_sel = test_sel[index] from RST through REPORT; otherwise 0.
- busy=1 in every state except IDLE and DONE. done=1 only in DONE.
- Table inputs must be stable while busy; they are sampled at use.
- `reset` at any time: next cycle is IDLE with all outputs at reset values. The in-flight test is discarded and not reported.

## Timing
- Reset values: cpu_reset_n=0, load_req=0, load_id=0, probe_sel=0, busy=0, done=0, result_valid=0, result_id=0, result_pass=0, counts=0, fail_mask=0.
- All outputs are registered.
- start→cpu_reset_n low: already low. start→busy: 1 cycle.
- Per test with ack latency A (A ≥ 1, counted from the first load_req cycle): RESET_CYCLES + A + N + 2 cycles, from RST entry to REPORT exit.
- A load_ack coincident with the timeout cycle counts as success.
- result_valid is never asserted in consecutive cycles. pass_count + fail_count == NUM_TESTS when done=1.

## Test plan
- NUM_TESTS=3; expect={2, 0x14, 0x3fff0001}; cycles={25, 50, 50}; behavioural CPU model and loader acking after 3 cycles → three result_valid pulses with pass=1, pass_count=3, fail_count=0, fail_mask=0, done=1.
- Same setup with the model corrupting test 1's result to 0x15 → result_pass=0 only for id 1, fail_mask=3'b010, pass_count=2.
- Loader never acks test 2, LOAD_TIMEOUT=8 → test 2 fails after exactly 8 LOAD cycles, no RUN cycles for test 2, cpu_reset_n stays low throughout that test.
- Count cpu_reset_n high cycles per test with cycles={1, 0, 7} → exactly 2, 2, and 8 cycles (RUN + CHECK), and 0 is treated as 1.
- Assert `reset` during RUN of test 1 → next cycle is IDLE, all outputs at reset values, no result_valid. A later `start` runs all 3 tests from index 0.
- `start` pulsed while busy → ignored. `start` in DONE → counts cleared and a new run executes.
